fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Iterative IEEE-754 single-precision divider, fp_Z = fp_X / fp_Y. It is the inverse-operation companion to the combinational FP multiplier in the ALU. It uses the same operand, rounding-mode and flag conventions, and the same flush-to-zero treatment of subnormals. A radix-2 restoring quotient loop trades latency for area, and a start/busy/done handshake connects it to the ALU issue logic.

Parameters:
EXP_W, 8, exponent width (only default supported)
FRAC_W, 23, stored fraction width (only default supported)
BIAS, 127, exponent bias
Q_BITS, 26, quotient bits generated: 1 integer + 23 fraction + 2 extra for normalisation/guard

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
fp_X  in  32  dividend
fp_Y  in  32  divisor
r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others are treated as RNE
fp_Z  out  32  result; valid when done=1, held until next accepted start
ovrf  out  1  overflow
udrf  out  1  underflow (result flushed)
dz  out  1  divide by zero
nv  out  1  invalid operation
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE; fp_Z, ovrf, udrf, dz, nv, busy and done are all 0. Reset mid-operation aborts with no done pulse.
- Accept: edge with start=1 and busy=0 latches fp_X, fp_Y and r_mode, then busy=1. start while busy=1 is ignored. Inputs are not used after latching.
- FSM: IDLE -> UNPACK -> ITER (Q_BITS cycles) -> ROUND -> IDLE. UNPACK -> ROUND directly for special cases.
- done=1 for exactly one cycle. It rises 28 clocks after the accepting edge for normal operands, and 2 clocks after for special cases. busy drops in the same cycle done rises, so a new start is legal in that cycle.
- Flags are cleared on accept and written together with fp_Z.
- Operand classes: exponent field 0 means zero (subnormals flushed). Exponent field FF with fraction 0 means Inf. Exponent field FF with fraction nonzero means NaN.
- Sign: sign_Z = X[31] ^ Y[31], except NaN results, which use the canonical 0x7FC00000.
- Special cases, in priority order:
  - any NaN, 0/0, or Inf/Inf -> 0x7FC00000, nv=1
  - Inf/finite -> signed Inf
  - finite/Inf -> signed zero
  - nonzero/0 -> signed Inf, dz=1
  - 0/nonzero -> signed zero
- ITER: restoring division of {1,frac_X} by {1,frac_Y}. Each cycle: remainder R = 2R (26-bit wide), subtract the divisor if R >= divisor, shift one quotient bit into q[25:0] MSB-first.
- Normalise:
  - If q[25]=1: mantissa = q[24:2], guard = q[1], sticky = q[0] | (R != 0); exponent e = eX - eY + BIAS.
  - Else: mantissa = q[23:1], guard = q[0], sticky = (R != 0); exponent e = eX - eY + BIAS - 1.
  - e is held as a 10-bit signed value.
- Round (inexact = guard | sticky):
  - RNE: increment if guard & (sticky | lsb)
  - RTZ: never increment
  - RDN: increment if sign & inexact
  - RUP: increment if !sign & inexact
  - RMM: increment if guard
  - Mantissa carry-out: mantissa = 0 and e+1.
- Overflow, e >= 255 after rounding: ovrf=1. Result is Inf for RNE/RMM; max finite 0x7F7FFFFF magnitude for RTZ; Inf if negative else max finite for RDN; Inf if positive else max finite for RUP.
- Underflow, e <= 0: signed zero, udrf=1, regardless of r_mode.

Decomposition:
- Shared package fp_pkg holds:
  - rounding-mode enum r_mode_e
  - EXP_W, FRAC_W and BIAS
  - constants QNAN = 32'h7FC00000, POS_INF and MAX_FIN
  - the operand-class typedef {zero, inf, nan, normal}
- The rounder is shared with the multiplier's rounding stage. It is a natural sub-module, fp_round: combinational, taking mantissa, guard, sticky, sign and r_mode and returning the rounded mantissa and carry.
- The FSM and quotient datapath stay in fp_div_seq.

Test Plan:
- X=0x40C00000, Y=0x40000000, RNE, start -> done at +28 clocks, fp_Z=0x40400000, all flags 0.
- X=0x3F800000, Y=0x40400000: RNE -> 0x3EAAAAAB, RTZ -> 0x3EAAAAAA, RUP -> 0x3EAAAAAB. With X=0xBF800000, RDN -> 0xBEAAAAAB.
- Special cases, each with done at +2 clocks:
  - X=0x3F800000, Y=0x00000000 -> 0x7F800000, dz=1.
  - X=Y=0 -> 0x7FC00000, nv=1.
  - Y=0x00000001 (subnormal) -> treated as zero, dz=1.
- X=0x7F000000, Y=0x3E800000: RNE -> 0x7F800000, ovrf=1; RTZ -> 0x7F7FFFFF, ovrf=1.
- X=0x00800000, Y=0x40000000 -> fp_Z=0x00000000, udrf=1.
- Handshake/reset:
  - start pulsed again while busy -> ignored, first result unchanged.
  - rst_n low 10 clocks after start -> busy=0, done never pulses, fp_Z=0.
  - Next start completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision FP types, constants and operand classifier
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int Q_BITS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] MAX_FIN = 32'h7F7FFFFF;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } r_mode_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ITER,
    ST_ROUND
  } div_state_e;

  // Subnormals fall into CLS_ZERO: the datapath flushes them.
  function automatic op_class_e classify(input logic [31:0] v);
    if (v[30:23] == 8'h00)      return CLS_ZERO;
    else if (v[30:23] == 8'hFF) return (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    else                        return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - start/busy/done operand and result bundle for the divider
interface fp_div_seq_if;
  import fp_pkg::*;

  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;
  logic        nv;
  logic        busy;
  logic        done;

  modport master (
    output start, fp_X, fp_Y, r_mode,
    input  fp_Z, ovrf, udrf, dz, nv, busy, done
  );

  modport slave (
    input  start, fp_X, fp_Y, r_mode,
    output fp_Z, ovrf, udrf, dz, nv, busy, done
  );

endinterface

// File: rtl/fp_round.sv
// rtl/fp_round.sv - combinational mantissa rounder shared by the FP multiplier and divider
module fp_round
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] i_man,
  input  logic              i_guard,
  input  logic              i_sticky,
  input  logic              i_sign,
  input  r_mode_e           i_mode,
  output logic [FRAC_W-1:0] o_man,
  output logic              o_carry
);

  logic w_inexact;
  logic w_inc;

  always_comb begin
    w_inexact = i_guard | i_sticky;
    w_inc     = 1'b0;
    case (i_mode)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & w_inexact;
      RM_RUP:  w_inc = ~i_sign & w_inexact;
      RM_RMM:  w_inc = i_guard;
      default: w_inc = i_guard & (i_sticky | i_man[0]);
    endcase
    {o_carry, o_man} = {1'b0, i_man} + {{FRAC_W{1'b0}}, w_inc};
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative radix-2 restoring single-precision divider, fp_Z = fp_X / fp_Y
module fp_div_seq
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fp_div_seq_if.slave  bus
);

  div_state_e         r_state;
  logic [31:0]        r_x;
  logic [31:0]        r_y;
  r_mode_e            r_rm;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_div;
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic               r_spec;
  logic [31:0]        r_spec_z;
  logic               r_spec_nv;
  logic               r_spec_dz;

  op_class_e          w_cx;
  op_class_e          w_cy;
  logic               w_sign;
  logic               w_spec;
  logic [31:0]        w_spec_z;
  logic               w_spec_nv;
  logic               w_spec_dz;

  always_comb begin
    w_cx      = classify(r_x);
    w_cy      = classify(r_y);
    w_sign    = r_x[31] ^ r_y[31];
    w_spec    = 1'b1;
    w_spec_z  = 32'd0;
    w_spec_nv = 1'b0;
    w_spec_dz = 1'b0;
    if (w_cx == CLS_NAN || w_cy == CLS_NAN ||
        (w_cx == CLS_ZERO && w_cy == CLS_ZERO) ||
        (w_cx == CLS_INF && w_cy == CLS_INF)) begin
      w_spec_z  = QNAN;
      w_spec_nv = 1'b1;
    end else if (w_cx == CLS_INF) begin
      w_spec_z = {w_sign, POS_INF[30:0]};
    end else if (w_cy == CLS_INF) begin
      w_spec_z = {w_sign, 31'd0};
    end else if (w_cy == CLS_ZERO) begin
      w_spec_z  = {w_sign, POS_INF[30:0]};
      w_spec_dz = 1'b1;
    end else if (w_cx == CLS_ZERO) begin
      w_spec_z = {w_sign, 31'd0};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Remainder is kept pre-shifted: compare/subtract then shift, so q[25] is the integer bit.
  logic               w_ge;
  logic [25:0]        w_sub;

  assign w_ge  = (r_rem >= {2'b00, r_div});
  assign w_sub = r_rem - {2'b00, r_div};

  logic [FRAC_W-1:0]  w_man;
  logic               w_guard;
  logic               w_sticky;
  logic signed [9:0]  w_e;
  logic [FRAC_W-1:0]  w_man_rnd;
  logic               w_carry;
  logic signed [9:0]  w_e_rnd;
  logic               w_ovf_inf;

  always_comb begin
    if (r_q[25]) begin
      w_man    = r_q[24:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (r_rem != 26'd0);
      w_e      = r_exp;
    end else begin
      w_man    = r_q[23:1];
      w_guard  = r_q[0];
      w_sticky = (r_rem != 26'd0);
      w_e      = r_exp - 10'sd1;
    end
  end

  fp_round u_round (
    .i_man    (w_man),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .i_sign   (r_sign),
    .i_mode   (r_rm),
    .o_man    (w_man_rnd),
    .o_carry  (w_carry)
  );

  always_comb begin
    w_e_rnd = w_e + $signed({9'd0, w_carry});
    case (r_rm)
      RM_RTZ:  w_ovf_inf = 1'b0;
      RM_RDN:  w_ovf_inf = r_sign;
      RM_RUP:  w_ovf_inf = ~r_sign;
      default: w_ovf_inf = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_x       <= 32'd0;
      r_y       <= 32'd0;
      r_rm      <= RM_RNE;
      r_sign    <= 1'b0;
      r_exp     <= 10'sd0;
      r_div     <= 24'd0;
      r_rem     <= 26'd0;
      r_q       <= 26'd0;
      r_cnt     <= 5'd0;
      r_spec    <= 1'b0;
      r_spec_z  <= 32'd0;
      r_spec_nv <= 1'b0;
      r_spec_dz <= 1'b0;
      bus.fp_Z  <= 32'd0;
      bus.ovrf  <= 1'b0;
      bus.udrf  <= 1'b0;
      bus.dz    <= 1'b0;
      bus.nv    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x      <= bus.fp_X;
            r_y      <= bus.fp_Y;
            r_rm     <= (bus.r_mode > 3'd4) ? RM_RNE : r_mode_e'(bus.r_mode);
            bus.ovrf <= 1'b0;
            bus.udrf <= 1'b0;
            bus.dz   <= 1'b0;
            bus.nv   <= 1'b0;
            bus.busy <= 1'b1;
            r_state  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          r_sign    <= w_sign;
          r_exp     <= {2'b00, r_x[30:23]} - {2'b00, r_y[30:23]} + 10'(BIAS);
          r_rem     <= {3'b001, r_x[22:0]};
          r_div     <= {1'b1, r_y[22:0]};
          r_q       <= 26'd0;
          r_cnt     <= 5'd0;
          r_spec    <= w_spec;
          r_spec_z  <= w_spec_z;
          r_spec_nv <= w_spec_nv;
          r_spec_dz <= w_spec_dz;
          r_state   <= w_spec ? ST_ROUND : ST_ITER;
        end
        ST_ITER: begin
          r_rem <= {(w_ge ? w_sub[24:0] : r_rem[24:0]), 1'b0};
          r_q   <= {r_q[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(Q_BITS - 1)) r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (r_spec) begin
            bus.fp_Z <= r_spec_z;
            bus.nv   <= r_spec_nv;
            bus.dz   <= r_spec_dz;
          end else if (w_e <= 10'sd0) begin
            bus.fp_Z <= {r_sign, 31'd0};
            bus.udrf <= 1'b1;
          end else if (w_e_rnd >= 10'sd255) begin
            bus.fp_Z <= {r_sign, (w_ovf_inf ? POS_INF[30:0] : MAX_FIN[30:0])};
            bus.ovrf <= 1'b1;
          end else begin
            bus.fp_Z <= {r_sign, w_e_rnd[7:0], w_man_rnd};
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       output int lat);
    @(negedge clk);
    bus.fp_X = x; bus.fp_Y = y; bus.r_mode = m; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.fp_X = 32'hDEADBEEF; bus.fp_Y = 32'h12345678; bus.r_mode = 3'b111;
    wait_done(lat);
  endtask

  task automatic test_reset;
    n_tests++;
    if (bus.fp_Z !== 32'd0) begin n_fail++; $display("FAIL reset_fp_Z got %h want 00000000", bus.fp_Z); end
    n_tests++;
    if ({bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.ovrf, bus.udrf, bus.dz, bus.nv});
    end
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_normal;
    int lat;
    do_op(32'h40C00000, 32'h40000000, 3'b000, lat);
    n_tests++;
    if (lat !== 28) begin n_fail++; $display("FAIL normal_latency got %0d want 28", lat); end
    n_tests++;
    if (bus.fp_Z !== 32'h40400000) begin n_fail++; $display("FAIL normal_6div2 got %h want 40400000", bus.fp_Z); end
    n_tests++;
    if ({bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b0000) begin
      n_fail++; $display("FAIL normal_flags got %b want 0000", {bus.ovrf, bus.udrf, bus.dz, bus.nv});
    end
  endtask

  task automatic test_rounding;
    logic [31:0] xs [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000};
    logic [2:0]  ms [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    logic [31:0] zs [5] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAB};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(xs[i], 32'h40400000, ms[i], lat);
      n_tests++;
      if (lat !== 28 || bus.fp_Z !== zs[i]) begin
        n_fail++; $display("FAIL round_%0d got %h lat %0d want %h lat 28", i, bus.fp_Z, lat, zs[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [31:0] xs [7] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7F800000,
                            32'h3F800000, 32'hC0000000, 32'h7FC12345};
    logic [31:0] ys [7] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h40000000,
                            32'hFF800000, 32'h00000000, 32'h3F800000};
    logic [31:0] zs [7] = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7F800000,
                            32'h80000000, 32'hFF800000, 32'h7FC00000};
    logic [3:0]  fs [7] = '{4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(xs[i], ys[i], 3'b000, lat);
      n_tests++;
      if (lat !== 2 || bus.fp_Z !== zs[i] || {bus.ovrf, bus.udrf, bus.dz, bus.nv} !== fs[i]) begin
        n_fail++;
        $display("FAIL special_%0d got %h flags %b lat %0d want %h flags %b lat 2",
                 i, bus.fp_Z, {bus.ovrf, bus.udrf, bus.dz, bus.nv}, lat, zs[i], fs[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [2:0]  ms [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] zs [4] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(32'h7F000000, 32'h3E800000, ms[i], lat);
      n_tests++;
      if (bus.fp_Z !== zs[i] || {bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b1000) begin
        n_fail++;
        $display("FAIL overflow_%0d got %h flags %b want %h flags 1000",
                 i, bus.fp_Z, {bus.ovrf, bus.udrf, bus.dz, bus.nv}, zs[i]);
      end
    end
  endtask

  task automatic test_underflow;
    int lat;
    do_op(32'h00800000, 32'h40000000, 3'b011, lat);
    n_tests++;
    if (bus.fp_Z !== 32'h00000000 || {bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b0100) begin
      n_fail++;
      $display("FAIL underflow got %h flags %b want 00000000 flags 0100",
               bus.fp_Z, {bus.ovrf, bus.udrf, bus.dz, bus.nv});
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    bus.fp_X = 32'h40C00000; bus.fp_Y = 32'h40000000; bus.r_mode = 3'b000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        bus.start = 1'b1; bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40400000;
      end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin lat = i; break; end
    end
    n_tests++;
    if (lat !== 28 || bus.fp_Z !== 32'h40400000) begin
      n_fail++; $display("FAIL busy_ignore got %h lat %0d want 40400000 lat 28", bus.fp_Z, lat);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_abort;
    logic seen_done;
    @(negedge clk);
    bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'b000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fp_Z !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_state got busy %b done %b z %h want 0 0 00000000", bus.busy, bus.done, bus.fp_Z);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got done pulse want none"); end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(32'h40C00000, 32'h40000000, 3'b000, lat);
    n_tests++;
    if (lat !== 28 || bus.fp_Z !== 32'h40400000) begin
      n_fail++; $display("FAIL b2b_first got %h lat %0d want 40400000 lat 28", bus.fp_Z, lat);
    end
    bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'b001; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", bus.busy); end
    wait_done(lat);
    n_tests++;
    if (lat !== 28 || bus.fp_Z !== 32'h3EAAAAAA) begin
      n_fail++; $display("FAIL b2b_second got %h lat %0d want 3EAAAAAA lat 28", bus.fp_Z, lat);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.fp_X = 32'd0; bus.fp_Y = 32'd0; bus.r_mode = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst_n = 1'b1;
    test_normal;
    test_rounding;
    test_special;
    test_overflow;
    test_underflow;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
